// File: rtl/alt_vipitc121_fifo_reader_pkg.sv
// Shared types and constant helpers for the clocked-video-output read engine.
package alt_vipitc121_fifo_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_UFLOW = 2'd2
  } state_t;

  // Raster position qualifiers captured one cycle behind the counters.
  typedef struct packed {
    logic act;
    logic hs;
    logic vs;
    logic sof;
    logic pop;
    logic uflow;
  } stage1_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic int span_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // One spare bit keeps the counter compares clear of the wrap value.
  function automatic int cnt_width(input int total);
    return clog2(total) + 1;
  endfunction

  localparam int DEF_H_TOTAL = span_total(1920, 88, 44, 148);
  localparam int DEF_V_TOTAL = span_total(1080, 4, 5, 36);
  localparam int DEF_H_CW    = cnt_width(DEF_H_TOTAL);
  localparam int DEF_V_CW    = cnt_width(DEF_V_TOTAL);

endpackage

// File: rtl/alt_vipitc121_timing_gen.sv
// Free-running raster counters with active/sync/start-of-frame decode.
module alt_vipitc121_timing_gen
  import alt_vipitc121_fifo_reader_pkg::*;
#(
  parameter int H_ACTIVE = 1920,
  parameter int H_FP     = 88,
  parameter int H_SYNC   = 44,
  parameter int H_BP     = 148,
  parameter int V_ACTIVE = 1080,
  parameter int V_FP     = 4,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 36
) (
  input  logic rdclk,
  input  logic aclr,
  output logic act,
  output logic hs,
  output logic vs,
  output logic sof,
  output logic eof
);

  localparam int H_TOTAL = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HW      = cnt_width(H_TOTAL);
  localparam int VW      = cnt_width(V_TOTAL);

  localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT   = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_ACT   = VW'(V_ACTIVE);
  localparam logic [HW-1:0] HS_BEG  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END  = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] VS_BEG  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END  = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge rdclk or posedge aclr) begin
    if (aclr) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  assign act = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hs  = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
  assign vs  = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
  assign sof = (h_cnt == '0) && (v_cnt == '0);
  assign eof = (h_cnt == H_LAST) && (v_cnt == V_LAST);

endmodule

// File: rtl/alt_vipitc121_fifo_reader.sv
// Video-clock read engine: raster timing, FIFO pop control, underflow recovery.
// Optional build macro ALT_VIPITC_UFLOW_REPEAT_EN repeats the last popped pixel after an underflow.
module alt_vipitc121_fifo_reader
  import alt_vipitc121_fifo_reader_pkg::*;
#(
  parameter int DATA_WIDTH  = 20,
  parameter int DATA_WIDTHU = 11,
  parameter int H_ACTIVE    = 1920,
  parameter int H_FP        = 88,
  parameter int H_SYNC      = 44,
  parameter int H_BP        = 148,
  parameter int V_ACTIVE    = 1080,
  parameter int V_FP        = 4,
  parameter int V_SYNC      = 5,
  parameter int V_BP        = 36,
  parameter int START_LEVEL = 960
) (
  input  logic                   rdclk,
  input  logic                   aclr,
  output logic                   rdreq,
  input  logic [DATA_WIDTH-1:0]  q,
  input  logic                   rdempty,
  input  logic [DATA_WIDTHU-1:0] rdusedw,
  input  logic                   clr_status,
  output logic [DATA_WIDTH-1:0]  vid_data,
  output logic                   vid_de,
  output logic                   vid_hsync,
  output logic                   vid_vsync,
  output logic                   vid_sof,
  output logic                   running,
  output logic                   underflow,
  output logic                   underflow_sticky
);

  localparam logic [DATA_WIDTHU-1:0] START_LVL = DATA_WIDTHU'(START_LEVEL);

  logic t_act, t_hs, t_vs, t_sof, t_eof;

  alt_vipitc121_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .rdclk (rdclk),
    .aclr  (aclr),
    .act   (t_act),
    .hs    (t_hs),
    .vs    (t_vs),
    .sof   (t_sof),
    .eof   (t_eof)
  );

  state_t  state, state_nxt;
  logic    pop, uflow_evt;
  stage1_t s1;

  always_ff @(posedge rdclk or posedge aclr) begin
    if (aclr) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    uflow_evt = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (t_sof && (rdusedw >= START_LVL)) begin
          state_nxt = ST_RUN;
          pop       = ~rdempty;
        end
      end
      ST_RUN: begin
        if (t_act) begin
          if (rdempty) begin
            uflow_evt = 1'b1;
            state_nxt = ST_UFLOW;
          end else begin
            pop = 1'b1;
          end
        end
      end
      ST_UFLOW: begin
        if (t_eof) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // The pop strobe is masked during reset because the counters sit on a sof position.
  assign rdreq = pop & ~aclr;

  always_ff @(posedge rdclk or posedge aclr) begin
    if (aclr) s1 <= '0;
    else      s1 <= '{act: t_act, hs: t_hs, vs: t_vs, sof: t_sof, pop: pop, uflow: uflow_evt};
  end

  logic [DATA_WIDTH-1:0] fill_px;

`ifdef ALT_VIPITC_UFLOW_REPEAT_EN
  logic                  s1_rep;
  logic [DATA_WIDTH-1:0] hold_px;

  always_ff @(posedge rdclk or posedge aclr) begin
    if (aclr) begin
      s1_rep  <= 1'b0;
      hold_px <= '0;
    end else begin
      s1_rep <= uflow_evt | ((state == ST_UFLOW) & t_act);
      if (s1.pop) hold_px <= q;
    end
  end

  assign fill_px = s1_rep ? hold_px : '0;
`else
  assign fill_px = '0;
`endif

  always_ff @(posedge rdclk or posedge aclr) begin
    if (aclr) begin
      vid_data         <= '0;
      vid_de           <= 1'b0;
      vid_hsync        <= 1'b0;
      vid_vsync        <= 1'b0;
      vid_sof          <= 1'b0;
      running          <= 1'b0;
      underflow        <= 1'b0;
      underflow_sticky <= 1'b0;
    end else begin
      vid_data         <= s1.pop ? q : fill_px;
      vid_de           <= s1.act;
      vid_hsync        <= s1.hs;
      vid_vsync        <= s1.vs;
      vid_sof          <= s1.sof;
      running          <= (state_nxt == ST_RUN);
      underflow        <= s1.uflow;
      underflow_sticky <= s1.uflow | (underflow_sticky & ~clr_status);
    end
  end

endmodule

// File: tb/tb_alt_vipitc121_fifo_reader.sv
// Self-checking bench for alt_vipitc121_fifo_reader on a 14x7 raster with a FIFO model.
module tb_alt_vipitc121_fifo_reader;

  localparam int DW      = 20;
  localparam int DWU     = 11;
  localparam int H_TOT   = 14;
  localparam int V_TOT   = 7;
  localparam int FRAME   = H_TOT * V_TOT;
`ifdef ALT_VIPITC_UFLOW_REPEAT_EN
  localparam logic [DW-1:0] REP_UF1 = 20'd52;
`else
  localparam logic [DW-1:0] REP_UF1 = 20'd0;
`endif

  logic           rdclk = 1'b0;
  logic           aclr = 1'b1;
  logic           clr_status = 1'b0;
  logic           wr_en = 1'b0;
  logic [DW-1:0]  wr_data = '0;
  logic           rdreq;
  logic [DW-1:0]  q = '0;
  logic           rdempty = 1'b1;
  logic [DWU-1:0] rdusedw = '0;
  logic [DW-1:0]  vid_data;
  logic           vid_de, vid_hsync, vid_vsync, vid_sof;
  logic           running, underflow, underflow_sticky;

  logic [DW-1:0] fifo[$];
  logic [DW-1:0] exp_q[$];

  int tests = 0, fails = 0, viol = 0, uf_seen = 0, nz_seen = 0;
  int h_m, v_m, d1_h, d1_v, d2_h, d2_v;
  logic d1_ok, d2_ok;

  alt_vipitc121_fifo_reader #(
    .DATA_WIDTH (DW), .DATA_WIDTHU (DWU),
    .H_ACTIVE (8), .H_FP (2), .H_SYNC (2), .H_BP (2),
    .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
    .START_LEVEL (8)
  ) dut (
    .rdclk (rdclk), .aclr (aclr), .rdreq (rdreq), .q (q), .rdempty (rdempty),
    .rdusedw (rdusedw), .clr_status (clr_status), .vid_data (vid_data),
    .vid_de (vid_de), .vid_hsync (vid_hsync), .vid_vsync (vid_vsync),
    .vid_sof (vid_sof), .running (running), .underflow (underflow),
    .underflow_sticky (underflow_sticky)
  );

  always #5 rdclk = ~rdclk;

  // FIFO model: 1-cycle read latency, writes visible after the next edge.
  always @(posedge rdclk) begin
    if (rdreq && fifo.size() > 0) q <= fifo.pop_front();
    if (wr_en) fifo.push_back(wr_data);
    rdusedw <= DWU'(fifo.size());
    rdempty <= (fifo.size() == 0);
  end

  // Reference raster position and its two-cycle delayed copy.
  always @(posedge rdclk or posedge aclr) begin
    if (aclr) begin
      h_m <= 0; v_m <= 0; d1_h <= 0; d1_v <= 0; d2_h <= 0; d2_v <= 0;
      d1_ok <= 1'b0; d2_ok <= 1'b0;
    end else begin
      d1_h <= h_m; d1_v <= v_m; d1_ok <= 1'b1;
      d2_h <= d1_h; d2_v <= d1_v; d2_ok <= d1_ok;
      if (h_m == H_TOT - 1) begin
        h_m <= 0;
        v_m <= (v_m == V_TOT - 1) ? 0 : v_m + 1;
      end else begin
        h_m <= h_m + 1;
      end
    end
  end

  function automatic logic [DW+7:0] all_outs();
    return {rdreq, vid_data, vid_de, vid_hsync, vid_vsync, vid_sof, running, underflow, underflow_sticky};
  endfunction

  // Advance one cycle and run the scoreboard on the sample taken at the falling edge.
  task automatic step();
    logic [DW-1:0] e;
    @(negedge rdclk);
    if (rdreq && rdempty) viol++;
    if (underflow) uf_seen++;
    if (vid_data != '0) begin
      nz_seen++;
      if (vid_de && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        tests++;
        if (vid_data !== e) begin
          fails++;
          $display("FAIL sb_pixel: got %0d expected %0d", vid_data, e);
        end
      end
    end
  endtask

  task automatic go_to(input int h, input int v);
    int n;
    n = 0;
    while (!(h_m == h && v_m == v) && n < 400) begin
      step();
      n++;
    end
    if (n >= 400) begin
      tests++; fails++;
      $display("FAIL go_to_timeout: position (%0d,%0d) not reached, wanted (%0d,%0d)", h_m, v_m, h, v);
    end
  endtask

  task automatic push_words(input logic [DW-1:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      wr_en   = 1'b1;
      wr_data = first + DW'(i);
      exp_q.push_back(first + DW'(i));
      step();
    end
    wr_en = 1'b0;
  endtask

  task automatic check_timing(input int n);
    int e_de, e_hs, e_vs, e_sof;
    logic xde, xhs, xvs, xsof;
    e_de = 0; e_hs = 0; e_vs = 0; e_sof = 0;
    for (int i = 0; i < n; i++) begin
      step();
      xde  = d2_ok && d2_h < 8 && d2_v < 4;
      xhs  = d2_ok && d2_h >= 10 && d2_h < 12;
      xvs  = d2_ok && d2_v == 5;
      xsof = d2_ok && d2_h == 0 && d2_v == 0;
      if (vid_de !== xde) e_de++;
      if (vid_hsync !== xhs) e_hs++;
      if (vid_vsync !== xvs) e_vs++;
      if (vid_sof !== xsof) e_sof++;
    end
    tests++; if (e_de != 0) begin fails++; $display("FAIL timing_de: %0d wrong cycles, expected 0", e_de); end
    tests++; if (e_hs != 0) begin fails++; $display("FAIL timing_hsync: %0d wrong cycles, expected 0", e_hs); end
    tests++; if (e_vs != 0) begin fails++; $display("FAIL timing_vsync: %0d wrong cycles, expected 0", e_vs); end
    tests++; if (e_sof != 0) begin fails++; $display("FAIL timing_sof: %0d wrong cycles, expected 0", e_sof); end
  endtask

  task automatic test_reset();
    aclr = 1'b1;
    repeat (3) step();
    tests++;
    if (all_outs() !== '0) begin fails++; $display("FAIL reset_outputs: got %h expected 0", all_outs()); end
    aclr = 1'b0;
  endtask

  task automatic test_sync();
    check_timing(2 * FRAME + 2);
  endtask

  task automatic test_start_threshold();
    int nz0;
    go_to(0, 5);
    push_words(20'd1, 7);
    go_to(0, 0);
    tests++; if (rdreq !== 1'b0) begin fails++; $display("FAIL thr_low_rdreq: got %b expected 0", rdreq); end
    nz0 = nz_seen;
    go_to(0, 5);
    tests++; if (nz_seen != nz0) begin fails++; $display("FAIL thr_low_data: %0d nonzero pixels, expected 0", nz_seen - nz0); end
    tests++; if (running !== 1'b0) begin fails++; $display("FAIL thr_low_running: got %b expected 0", running); end
    push_words(20'd8, 25);
    go_to(0, 0);
    tests++; if (rdreq !== 1'b1) begin fails++; $display("FAIL thr_high_rdreq: got %b expected 1", rdreq); end
    step();
    tests++; if (running !== 1'b1) begin fails++; $display("FAIL thr_running: got %b expected 1", running); end
    for (int i = 0; i < 6 && !vid_sof; i++) step();
    tests++;
    if (vid_sof !== 1'b1 || vid_de !== 1'b1 || vid_data !== 20'd1) begin
      fails++; $display("FAIL thr_sof_pixel: sof=%b de=%b data=%0d expected 1 1 1", vid_sof, vid_de, vid_data);
    end
    go_to(0, 4);
    tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL thr_drain: %0d pixels missing, expected 0", exp_q.size()); end
  endtask

  task automatic test_underflow();
    int uf0, bad, n;
    push_words(20'd33, 20);
    uf0 = uf_seen;
    go_to(6, 2);
    tests++; if (underflow !== 1'b1) begin fails++; $display("FAIL uf_pulse: got %b expected 1", underflow); end
    tests++;
    if (vid_de !== 1'b1 || vid_data !== REP_UF1) begin
      fails++; $display("FAIL uf_pixel: de=%b data=%0d expected 1 %0d", vid_de, vid_data, REP_UF1);
    end
    tests++; if (underflow_sticky !== 1'b1) begin fails++; $display("FAIL uf_sticky: got %b expected 1", underflow_sticky); end
    tests++; if (running !== 1'b0) begin fails++; $display("FAIL uf_running: got %b expected 0", running); end
    tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL uf_drain: %0d pixels missing, expected 0", exp_q.size()); end
    step();
    tests++; if (underflow !== 1'b0) begin fails++; $display("FAIL uf_pulse_width: got %b expected 0", underflow); end
    bad = 0; n = 0;
    while (!(h_m == 0 && v_m == 4) && n < 200) begin
      step();
      n++;
      if (vid_de && vid_data !== REP_UF1) bad++;
    end
    tests++; if (bad != 0 || n >= 200) begin fails++; $display("FAIL uf_fill: %0d pixels not %0d, expected 0", bad, REP_UF1); end
    tests++; if (uf_seen - uf0 != 1) begin fails++; $display("FAIL uf_count: got %0d pulses expected 1", uf_seen - uf0); end
  endtask

  task automatic test_sticky();
    clr_status = 1'b1;
    step();
    clr_status = 1'b0;
    tests++; if (underflow_sticky !== 1'b0) begin fails++; $display("FAIL sticky_clear: got %b expected 0", underflow_sticky); end
    push_words(20'd53, 10);
    go_to(3, 1);
    clr_status = 1'b1;
    step();
    clr_status = 1'b0;
    tests++;
    if (underflow !== 1'b1 || underflow_sticky !== 1'b1) begin
      fails++; $display("FAIL sticky_priority: uf=%b sticky=%b expected 1 1", underflow, underflow_sticky);
    end
    step();
    tests++; if (underflow_sticky !== 1'b1) begin fails++; $display("FAIL sticky_hold: got %b expected 1", underflow_sticky); end
    tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL refill_drain: %0d pixels missing, expected 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid_line();
    int nz0;
    go_to(5, 2);
    aclr = 1'b1;
    #1;
    tests++; if (all_outs() !== '0) begin fails++; $display("FAIL rst_mid_now: got %h expected 0", all_outs()); end
    repeat (3) step();
    tests++; if (all_outs() !== '0) begin fails++; $display("FAIL rst_mid_hold: got %h expected 0", all_outs()); end
    aclr = 1'b0;
    nz0 = nz_seen;
    check_timing(FRAME);
    tests++; if (running !== 1'b0) begin fails++; $display("FAIL rst_mid_idle: got %b expected 0", running); end
    tests++; if (nz_seen != nz0) begin fails++; $display("FAIL rst_mid_data: %0d nonzero pixels, expected 0", nz_seen - nz0); end
  endtask

  initial begin
    test_reset();
    test_sync();
    test_start_threshold();
    test_underflow();
    test_sticky();
    test_reset_mid_line();
    tests++; if (viol != 0) begin fails++; $display("FAIL rdreq_when_empty: %0d cycles, expected 0", viol); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
